// File: rtl/nios_system_bme_spi_master_if.sv
// Avalon-MM slave bus bundle for the BME280 SPI master.
// slave: DUT side (address/strobes/writedata in, readdata out); master: Nios side.
interface nios_system_bme_spi_master_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic        read_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport slave (
    input  address, chipselect, write_n, read_n, writedata,
    output readdata
  );

  modport master (
    output address, chipselect, write_n, read_n, writedata,
    input  readdata
  );
endinterface

// File: rtl/nios_system_bme_spi_master.sv
// Byte-wide SPI master (mode 0, MSB first) for the BME280, Avalon-MM slave.
// Ports: clk, reset_n (sync, active-low), bus (Avalon slave modport),
// bme_csn/bme_sclk/bme_mosi out, bme_miso in; irq out when BME_SPI_IRQ_EN defined.
// Regs: 0 TXDATA(W) 1 RXDATA(R) 2 STATUS{wr_err,rx_ready,busy} 3 CONTROL{irq_en,cs}.
module nios_system_bme_spi_master #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset_n,
  nios_system_bme_spi_master_if.slave bus,
  output logic bme_csn,
  output logic bme_sclk,
  output logic bme_mosi,
  input  logic bme_miso
`ifdef BME_SPI_IRQ_EN
  ,
  output logic irq
`endif
);

  localparam int DW = $clog2(CLK_DIV + 1);
  localparam logic [DW-1:0] LAST = DW'(CLK_DIV - 1);

  typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] div_q, div_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    rx_q, rx_d;
  logic          busy_q, busy_d;
  logic          rdy_q, rdy_d;
  logic          err_q, err_d;
  logic          cs_q, cs_d;
  logic          csn_q, csn_d;
  logic          sclk_q, sclk_d;
  logic          mosi_q, mosi_d;
`ifdef BME_SPI_IRQ_EN
  logic          ien_q, ien_d;
`endif

  logic wr, wr_tx, wr_st, wr_ctl, rd_rx, ctl_b1;
  logic unused_ok;

  assign wr     = bus.chipselect & ~bus.write_n;
  assign wr_tx  = wr && (bus.address == 2'd0);
  assign wr_st  = wr && (bus.address == 2'd2);
  assign wr_ctl = wr && (bus.address == 2'd3);
  assign rd_rx  = bus.chipselect & ~bus.read_n
                  & (bus.address == 2'd1);
  assign unused_ok = &{1'b0, bus.writedata[31:8]};

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    rx_d    = rx_q;
    busy_d  = busy_q;
    rdy_d   = rdy_q;
    err_d   = err_q;
    cs_d    = cs_q;
    sclk_d  = sclk_q;
    mosi_d  = mosi_q;
`ifdef BME_SPI_IRQ_EN
    ien_d   = ien_q;
`endif

    if (rd_rx) rdy_d = 1'b0;
    if (wr_st && bus.writedata[2]) err_d = 1'b0;
    if (wr_tx && busy_q) err_d = 1'b1;
    if (wr_ctl) begin
      // Chip select is frozen for the whole byte.
      if (busy_q) begin
        err_d = 1'b1;
      end else begin
        cs_d  = bus.writedata[0];
`ifdef BME_SPI_IRQ_EN
        ien_d = bus.writedata[1];
`endif
      end
    end

    unique case (state_q)
      IDLE: begin
        if (wr_tx) begin
          shift_d = bus.writedata[7:0];
          mosi_d  = bus.writedata[7];
          bit_d   = 3'd7;
          div_d   = '0;
          busy_d  = 1'b1;
          state_d = LOW;
        end
      end
      LOW: begin
        if (div_q == LAST) begin
          // Rising edge: capture MISO; shift[7] becomes the next TX bit.
          div_d   = '0;
          sclk_d  = 1'b1;
          shift_d = {shift_q[6:0], bme_miso};
          state_d = HIGH;
        end else begin
          div_d = div_q + DW'(1);
        end
      end
      HIGH: begin
        if (div_q == LAST) begin
          div_d  = '0;
          sclk_d = 1'b0;
          if (bit_q == 3'd0) begin
            state_d = DONE;
          end else begin
            bit_d   = bit_q - 3'd1;
            mosi_d  = shift_q[7];
            state_d = LOW;
          end
        end else begin
          div_d = div_q + DW'(1);
        end
      end
      DONE: begin
        rx_d    = shift_q;
        rdy_d   = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    csn_d = ~cs_d;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      div_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      rx_q    <= '0;
      busy_q  <= 1'b0;
      rdy_q   <= 1'b0;
      err_q   <= 1'b0;
      cs_q    <= 1'b0;
      csn_q   <= 1'b1;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b0;
`ifdef BME_SPI_IRQ_EN
      ien_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      rx_q    <= rx_d;
      busy_q  <= busy_d;
      rdy_q   <= rdy_d;
      err_q   <= err_d;
      cs_q    <= cs_d;
      csn_q   <= csn_d;
      sclk_q  <= sclk_d;
      mosi_q  <= mosi_d;
`ifdef BME_SPI_IRQ_EN
      ien_q   <= ien_d;
`endif
    end
  end

`ifdef BME_SPI_IRQ_EN
  assign ctl_b1 = ien_q;
  assign irq    = rdy_q & ien_q;
`else
  assign ctl_b1 = 1'b0;
`endif

  always_comb begin
    bus.readdata = '0;
    unique case (bus.address)
      2'd0: bus.readdata = '0;
      2'd1: bus.readdata = {24'd0, rx_q};
      2'd2: bus.readdata = {29'd0, err_q, rdy_q, busy_q};
      2'd3: bus.readdata = {30'd0, ctl_b1, cs_q};
      default: bus.readdata = '0;
    endcase
  end

  assign bme_csn  = csn_q;
  assign bme_sclk = sclk_q;
  assign bme_mosi = mosi_q;

endmodule

// File: tb/tb_nios_system_bme_spi_master.sv
// Directed self-checking bench for nios_system_bme_spi_master.
// MISO model: slave byte presented MSB first, advancing on SCLK falls.
module tb_nios_system_bme_spi_master;
  localparam int CLK_DIV = 4;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  nios_system_bme_spi_master_if bus();
  logic bme_csn, bme_sclk, bme_mosi, bme_miso;
`ifdef BME_SPI_IRQ_EN
  logic irq;
`endif

  nios_system_bme_spi_master #(.CLK_DIV(CLK_DIV)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .bus      (bus.slave),
    .bme_csn  (bme_csn),
    .bme_sclk (bme_sclk),
    .bme_mosi (bme_mosi),
    .bme_miso (bme_miso)
`ifdef BME_SPI_IRQ_EN
    ,
    .irq      (irq)
`endif
  );

  int checks = 0;
  int failures = 0;

  int rises = 0;
  int falls = 0;
  logic [7:0] mosi_cap = 8'h00;
  logic [7:0] slave_byte = 8'h00;
  int fall_base = 0;
  logic [31:0] idx;

  always @(posedge bme_sclk) begin
    mosi_cap <= {mosi_cap[6:0], bme_mosi};
    rises <= rises + 1;
  end
  always @(negedge bme_sclk) falls <= falls + 1;

  assign idx = falls - fall_base;
  assign bme_miso = (idx < 8) ? slave_byte[3'd7 - idx[2:0]] : 1'b0;

  task automatic av_write(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.chipselect = 1'b1; bus.write_n = 1'b0;
    bus.address = a; bus.writedata = d;
    @(negedge clk);
    bus.chipselect = 1'b0; bus.write_n = 1'b1;
  endtask

  task automatic av_read(input logic [1:0] a, output logic [31:0] d);
    @(negedge clk);
    bus.chipselect = 1'b1; bus.read_n = 1'b0; bus.address = a;
    #1 d = bus.readdata;
    @(negedge clk);
    bus.chipselect = 1'b0; bus.read_n = 1'b1;
  endtask

  task automatic wait_idle(output bit timed_out);
    bit done;
    done = 1'b0;
    bus.chipselect = 1'b1; bus.read_n = 1'b1; bus.address = 2'd2;
    for (int i = 0; i < 300 && !done; i++) begin
      @(posedge clk); #1;
      if (bus.readdata[0] == 1'b0) done = 1'b1;
    end
    bus.chipselect = 1'b0;
    timed_out = !done;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    bus.chipselect = 1'b1; bus.read_n = 1'b1;
    checks++;
    if (bme_csn !== 1'b1) begin
      failures++; $display("FAIL rst_csn: got %b want 1", bme_csn);
    end
    checks++;
    if (bme_sclk !== 1'b0) begin
      failures++; $display("FAIL rst_sclk: got %b want 0", bme_sclk);
    end
    checks++;
    if (bme_mosi !== 1'b0) begin
      failures++; $display("FAIL rst_mosi: got %b want 0", bme_mosi);
    end
    for (int a = 0; a < 4; a++) begin
      bus.address = 2'(a);
      #1;
      checks++;
      if (bus.readdata !== 32'h0) begin
        failures++;
        $display("FAIL rst_reg%0d: got %h want 0", a, bus.readdata);
      end
    end
    bus.chipselect = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_transfer();
    int r0, first_idle, sclk_err, k;
    logic exp_s;
    logic [31:0] d;
    av_write(2'd3, 32'h1);
    checks++;
    if (bme_csn !== 1'b0) begin
      failures++; $display("FAIL csn_assert: got %b want 0", bme_csn);
    end
    slave_byte = 8'h60; fall_base = falls; r0 = rises;
    first_idle = 0; sclk_err = 0;
    @(negedge clk);
    bus.chipselect = 1'b1; bus.write_n = 1'b0;
    bus.address = 2'd0; bus.writedata = 32'hD0;
    for (int n = 1; n <= 100 && first_idle == 0; n++) begin
      @(posedge clk); #1;
      if (n == 1) begin
        bus.write_n = 1'b1; bus.read_n = 1'b1; bus.address = 2'd2;
        checks++;
        if (bme_mosi !== 1'b1) begin
          failures++; $display("FAIL mosi_first: got %b want 1", bme_mosi);
        end
      end
      #1;
      k = n - 1;
      exp_s = (k >= 4 && k <= 63) ? ((k / 4) % 2 == 1) : 1'b0;
      if (bme_sclk !== exp_s) sclk_err++;
      if (bus.readdata[0] == 1'b0) first_idle = n;
    end
    bus.chipselect = 1'b0;
    checks++;
    if (first_idle != 66) begin
      failures++; $display("FAIL busy_latency: got %0d want 66", first_idle);
    end
    checks++;
    if (sclk_err != 0) begin
      failures++; $display("FAIL sclk_shape: got %0d bad cycles want 0", sclk_err);
    end
    checks++;
    if (rises - r0 != 8) begin
      failures++; $display("FAIL sclk_pulses: got %0d want 8", rises - r0);
    end
    checks++;
    if (mosi_cap !== 8'hD0) begin
      failures++; $display("FAIL mosi_D0: got %h want d0", mosi_cap);
    end
    av_read(2'd2, d);
    checks++;
    if (d !== 32'h2) begin
      failures++; $display("FAIL status_done: got %h want 2", d);
    end
  endtask

  task automatic test_rx_read();
    logic [31:0] d;
    av_read(2'd1, d);
    checks++;
    if (d !== 32'h60) begin
      failures++; $display("FAIL rxdata_60: got %h want 60", d);
    end
    av_read(2'd2, d);
    checks++;
    if (d !== 32'h0) begin
      failures++; $display("FAIL rx_ready_clr: got %h want 0", d);
    end
  endtask

  task automatic test_back_to_back();
    int r0;
    bit to;
    logic [31:0] d;
    slave_byte = 8'hA5; fall_base = falls; r0 = rises;
    av_write(2'd0, 32'hF4);
    repeat (10) @(posedge clk);
    av_write(2'd0, 32'h27);
    av_read(2'd2, d);
    checks++;
    if (d !== 32'h5) begin
      failures++; $display("FAIL status_busy_err: got %h want 5", d);
    end
    wait_idle(to);
    checks++;
    if (to) begin
      failures++; $display("FAIL b2b_timeout: got busy want idle");
    end
    checks++;
    if (mosi_cap !== 8'hF4 || rises - r0 != 8) begin
      failures++;
      $display("FAIL b2b_tx: got %h/%0d want f4/8", mosi_cap, rises - r0);
    end
    av_read(2'd2, d);
    checks++;
    if (d !== 32'h6) begin
      failures++; $display("FAIL b2b_status: got %h want 6", d);
    end
    av_read(2'd1, d);
    checks++;
    if (d !== 32'hA5) begin
      failures++; $display("FAIL rxdata_A5: got %h want a5", d);
    end
    av_write(2'd2, 32'h4);
    av_read(2'd2, d);
    checks++;
    if (d !== 32'h0) begin
      failures++; $display("FAIL err_clear: got %h want 0", d);
    end
  endtask

  task automatic test_ctl_busy_reset();
    int r0;
    bit hit;
    logic [31:0] d;
    slave_byte = 8'hFF; fall_base = falls; r0 = rises;
    av_write(2'd0, 32'h3C);
    repeat (5) @(posedge clk);
    av_write(2'd3, 32'h0);
    checks++;
    if (bme_csn !== 1'b0) begin
      failures++; $display("FAIL csn_hold: got %b want 0", bme_csn);
    end
    av_read(2'd2, d);
    checks++;
    if (d !== 32'h5) begin
      failures++; $display("FAIL ctl_err: got %h want 5", d);
    end
    av_read(2'd3, d);
    checks++;
    if (d !== 32'h1) begin
      failures++; $display("FAIL ctl_kept: got %h want 1", d);
    end
    hit = 1'b0;
    for (int i = 0; i < 200 && !hit; i++) begin
      @(posedge clk); #1;
      if (rises - r0 >= 4) hit = 1'b1;
    end
    checks++;
    if (!hit) begin
      failures++; $display("FAIL bit3_timeout: got %0d rises want 4", rises - r0);
    end
    @(negedge clk);
    reset_n = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (bme_csn !== 1'b1 || bme_sclk !== 1'b0) begin
      failures++;
      $display("FAIL mid_rst_pins: got csn=%b sclk=%b want 1/0", bme_csn, bme_sclk);
    end
    bus.chipselect = 1'b1; bus.read_n = 1'b1; bus.address = 2'd2;
    #1;
    checks++;
    if (bus.readdata !== 32'h0) begin
      failures++; $display("FAIL mid_rst_status: got %h want 0", bus.readdata);
    end
    bus.address = 2'd1;
    #1;
    checks++;
    if (bus.readdata !== 32'h0) begin
      failures++; $display("FAIL mid_rst_rx: got %h want 0", bus.readdata);
    end
    bus.chipselect = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

`ifdef BME_SPI_IRQ_EN
  task automatic test_irq();
    bit to;
    logic [31:0] d;
    av_write(2'd3, 32'h3);
    slave_byte = 8'h00; fall_base = falls;
    av_write(2'd0, 32'h00);
    checks++;
    if (irq !== 1'b0) begin
      failures++; $display("FAIL irq_busy: got %b want 0", irq);
    end
    wait_idle(to);
    checks++;
    if (to || irq !== 1'b1) begin
      failures++; $display("FAIL irq_set: got %b want 1", irq);
    end
    av_read(2'd1, d);
    #1;
    checks++;
    if (irq !== 1'b0) begin
      failures++; $display("FAIL irq_clr: got %b want 0", irq);
    end
  endtask
`endif

  initial begin
    bus.chipselect = 1'b0; bus.write_n = 1'b1; bus.read_n = 1'b1;
    bus.address = 2'd0; bus.writedata = 32'h0;
    test_reset();
    test_transfer();
    test_rx_read();
    test_back_to_back();
    test_ctl_busy_reset();
`ifdef BME_SPI_IRQ_EN
    test_irq();
`endif
    repeat (4) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
